// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg: shared fetch-stage types, defaults and RV32 opcodes        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_reg: IF/ID pipeline register with one-entry hold buffer         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        capture,
  input  logic        hold_release,
  input  logic        consume,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  if_opcode
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    opcode_d     = opcode_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;

    if (flush) begin
      valid_d  = 1'b0;
      instr_d  = NOP_INSTR;
      opcode_d = NOP_INSTR[6:0];
    end else if (load) begin
      valid_d  = 1'b1;
      pc_d     = in_pc;
      instr_d  = in_instr;
      opcode_d = in_instr[6:0];
    end else if (hold_release) begin
      valid_d  = 1'b1;
      pc_d     = hold_pc_q;
      instr_d  = hold_instr_q;
      opcode_d = hold_instr_q[6:0];
    end else if (consume) begin
      valid_d = 1'b0;
    end

    // Buffer contents are only meaningful while the FSM sits in HOLD, so a
    // flush discards them simply by leaving that state.
    if (capture && !flush) begin
      hold_pc_d    = in_pc;
      hold_instr_d = in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      opcode_q     <= NOP_INSTR[6:0];
      hold_pc_q    <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      opcode_q     <= opcode_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign if_valid  = valid_q;
  assign if_pc     = pc_q;
  assign if_instr  = instr_q;
  assign if_opcode = opcode_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_unit: PC, single-outstanding fetch FSM, stall / redirect  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  if_opcode
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         consume, slot_free;
  logic         load, capture, hold_release, flush;

  assign consume   = if_valid && !stall;
  assign slot_free = !if_valid || consume;
  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    load         = 1'b0;
    capture      = 1'b0;
    hold_release = 1'b0;
    flush        = 1'b0;

    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = redirect_pc & 32'hFFFF_FFFC;
      // An already-accepted fetch must have its response drained first.
      case (state_q)
        ST_REQ:            state_d = imem_ready  ? ST_DRAIN : ST_REQ;
        ST_WAIT, ST_DRAIN: state_d = imem_rvalid ? ST_REQ   : ST_DRAIN;
        default:           state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (imem_ready) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (slot_free) begin
              load    = 1'b1;
              pc_d    = pc_q + 32'd4;
              state_d = ST_REQ;
            end else begin
              capture = 1'b1;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (slot_free) begin
            hold_release = 1'b1;
            pc_d         = pc_q + 32'd4;
            state_d      = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) state_d = ST_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .load         (load),
    .capture      (capture),
    .hold_release (hold_release),
    .consume      (consume),
    .in_instr     (imem_rdata),
    .in_pc        (pc_q),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_opcode    (if_opcode)
  );

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of the opcode decoder (control unit).
- Owns the PC and issues single-outstanding word fetches to instruction memory.
- Holds the fetched instruction in an IF/ID register and presents if_opcode = if_instr[6:0] to the decoder.
- Handles decode-stage stall and branch/jump redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, IF/ID instruction value on reset and flush (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; always equals the pc register.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- stall  in  1  decode stage cannot accept a new instruction.
- redirect_valid  in  1  taken branch/JAL/JALR.
- redirect_pc  in  32  redirect target.
- if_valid  out  1  IF/ID holds a valid instruction.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  fetched instruction.
- if_opcode  out  7  if_instr[6:0], registered together with if_instr.

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, if_valid=0, if_pc=RESET_PC, if_instr=NOP_INSTR, if_opcode=7'b0010011, hold buffer empty.
- imem_req=1 only in state REQ and is combinational from the state. imem_addr=pc always.
- Handshake:
  - A request is accepted on the cycle imem_req && imem_ready.
  - At most one request is outstanding.
  - imem_rvalid outside WAIT/DRAIN is ignored.
- Consumer transfer: an IF/ID instruction is consumed on the cycle if_valid && !stall.
- Slot free: if_valid==0 or the current instruction is being consumed this cycle.
- FSM transitions:
  - IDLE -> REQ: unconditionally, so the first request occurs in the first cycle after rst deasserts.
  - REQ -> WAIT: on imem_ready. Otherwise stay in REQ with address held.
  - WAIT, on imem_rvalid with slot free: load if_instr/if_opcode=imem_rdata, if_pc=pc, if_valid=1; pc<=pc+4; -> REQ.
  - WAIT, on imem_rvalid with slot not free: capture rdata and pc into the hold buffer; -> HOLD.
  - HOLD -> REQ: when the slot frees, move the buffer to IF/ID, set pc<=pc+4.
  - DRAIN -> REQ: on imem_rvalid, discard the data.
- If no consumer transfer occurs and nothing loads, if_valid and all if_* outputs hold.
- Redirect (redirect_valid=1) has highest priority over stall and normal flow:
  - pc<=redirect_pc with bits [1:0] forced to 00.
  - if_valid<=0, if_instr<=NOP_INSTR, hold buffer discarded.
  - Next state depends on where the fetch was:
    - IDLE/REQ without acceptance, HOLD, or WAIT with imem_rvalid the same cycle (data discarded): -> REQ.
    - REQ with imem_ready the same cycle (old address already accepted): -> DRAIN.
    - WAIT without rvalid: -> DRAIN.
    - DRAIN: stay in DRAIN, but -> REQ if imem_rvalid arrives the same cycle.
- Simultaneous redirect and stall: redirect wins and the IF/ID register is flushed regardless of stall.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- rst asserted mid-operation returns to reset values next edge; an outstanding response after reset is ignored because the state is IDLE/REQ.
- Throughput: one instruction per two cycles with zero-wait memory (request cycle + response cycle).

Decomposition:
- Shared package fetch_pkg:
  - FSM state enum IDLE/REQ/WAIT/HOLD/DRAIN.
  - NOP_INSTR and RESET_PC defaults.
  - RV32 opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR), shared with the control unit.
- One natural sub-module: if_id_reg, the IF/ID register with valid, load, flush and hold, including the one-entry hold buffer. PC and FSM stay in the top.

Test Plan:
- Reset, then zero-wait memory returning 32'h00500093 at addr 0 -> first imem_req in cycle 1 after rst low with imem_addr=0; if_valid=1, if_pc=0, if_opcode=7'b0010011; next imem_addr=4.
- Stall held 3 cycles while rvalid returns word at addr 4 -> if_* stays at the addr 0 instruction; HOLD entered; on stall release if_pc=4 and the next request is addr 8.
- Redirect to 32'h0000_0103 during WAIT without rvalid -> DRAIN; the following rvalid data is dropped (if_valid stays 0); next imem_addr=32'h0000_0100.
- Redirect the same cycle as imem_ready at addr 8 -> DRAIN; the stale response is discarded; the first instruction delivered has if_pc=the redirect target.
- Redirect with stall=1 and if_valid=1 -> if_valid=0 and if_instr=32'h00000013 next cycle.
- pc=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0000_0000; rst asserted mid-WAIT -> if_valid=0, pc=RESET_PC, and the late rvalid is ignored.
